lsu_store_align: RTL and testbench
==================================

Name: lsu_store_align

Overview:
- Parametrised store-path byte-lane decoder for the LSU memory-access stage.
- Generalises the 2-to-4 lane decoder: handles DATA_W/8 lanes and access sizes byte through doubleword.
- Shifts store data onto the selected lanes and flags misaligned or illegal accesses.
- Registered single-stage pipeline with valid/ready handshake, plus a saturating misalignment event counter.

Parameters:
DATA_W, 32, store bus width in bits; legal values 32 or 64.
NB, DATA_W/8, number of byte lanes (derived, not overridden).
OFS_W, $clog2(NB), width of address byte offset (derived).
CNT_W, 8, width of misalignment event counter.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  reset, asynchronous, active-high.
i_valid  in  1  upstream request valid.
o_ready  out  1  stage can accept request this cycle.
i_addr  in  OFS_W  low byte-offset bits of store address.
i_size  in  2  00 byte, 01 half, 10 word, 11 double.
i_wdata  in  DATA_W  store data, right-justified.
o_valid  out  1  output holds valid result.
i_ready  in  1  downstream accepts result.
o_bmask  out  NB  one-hot-run byte-lane enable.
o_wdata  out  DATA_W  lane-aligned store data.
o_misalign  out  1  result is misaligned/illegal; o_bmask is zero.
o_mis_cnt  out  CNT_W  count of misaligned results accepted downstream.

Behaviour:
- Clock and reset: one clock i_clk; i_rst asynchronous, active-high.
- Reset values: o_valid=0, o_bmask=0, o_wdata=0, o_misalign=0, o_mis_cnt=0.
- Handshake: o_ready = !o_valid | i_ready (combinational). Accept on i_valid & o_ready. Transfer out on o_valid & i_ready.
- Latency: exactly 1 cycle from accept to o_valid. Full throughput (one per cycle) while i_ready=1.
- Register update:
  - On accept: output regs load the new result; o_valid=1.
  - On transfer without accept: o_valid=0; data regs hold.
  - On stall (o_valid & !i_ready): all outputs hold stable. Upstream is blocked since o_ready=0.
- Size bytes: SZ = 1<<i_size.
- Illegal: i_size=11 when DATA_W=32.
- Misaligned: (i_addr & (SZ-1)) != 0.
- If illegal or misaligned: o_bmask=0, o_wdata=0, o_misalign=1.
- Otherwise:
  - o_bmask = ((1<<SZ)-1) << i_addr.
  - o_wdata lane k = i_wdata byte (k - i_addr) for enabled lanes; disabled lanes are 0.
  - o_misalign=0.
- Word on 32-bit bus: i_addr must be 0; o_bmask=1111. Double on 64-bit bus: i_addr must be 0; mask all ones.
- Counter: o_mis_cnt increments on each transfer (o_valid & i_ready) with o_misalign=1. Saturates at 2^CNT_W-1; no wrap. Cleared only by i_rst.
- Simultaneous transfer and accept: new result loads and o_valid stays 1. The counter still counts the departing result.
- Reset mid-operation: pending result discarded immediately (asynchronous); o_valid=0 without waiting for the clock.

Test Plan:
- DATA_W=32; byte stores at addr 0..3, wdata=0x000000A5, i_ready=1 -> o_bmask 0001/0010/0100/1000; o_wdata 0xA5, 0xA500, 0xA50000, 0xA5000000; one per cycle, latency 1.
- DATA_W=32; half at addr 2, wdata=0x1234 -> o_bmask=1100, o_wdata=0x12340000. Half at addr 1 -> o_bmask=0000, o_wdata=0, o_misalign=1, o_mis_cnt 0->1.
- DATA_W=32; size=11 -> o_misalign=1. DATA_W=64; double at addr 0, wdata=0x0123456789ABCDEF -> o_bmask=0xFF, data unchanged.
- Hold i_ready=0 for 3 cycles after one accept -> o_ready=0; o_valid, o_bmask, o_wdata stable; second request not accepted until i_ready=1. o_mis_cnt changes only on transfer.
- CNT_W=2; five misaligned transfers -> o_mis_cnt 1,2,3,3,3.
- Assert i_rst asynchronously mid-cycle with o_valid=1 and o_mis_cnt=2 -> o_valid, o_bmask, o_mis_cnt go 0 before the next edge; first accept after release yields normal result.

Source files
------------

// File: rtl/lsu_store_align.sv
// Store-path byte-lane decoder: places right-justified store data onto the addressed
// byte lanes, flags misaligned/illegal accesses, and counts misaligned results sent downstream.
module lsu_store_align #(
    parameter  int DATA_W = 32,
    parameter  int CNT_W  = 8,
    localparam int NB     = DATA_W / 8,
    localparam int OFS_W  = $clog2(NB)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [OFS_W-1:0]  i_addr,
    input  logic [1:0]        i_size,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [NB-1:0]     o_bmask,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_misalign,
    output logic [CNT_W-1:0]  o_mis_cnt
);

    logic [NB-1:0]     sizeMask;
    logic [OFS_W-1:0]  ofsMask;
    logic [DATA_W-1:0] laneMask;
    logic [OFS_W+2:0]  shiftAmt;
    logic              illegal;
    logic              misalign_d;
    logic [NB-1:0]     bmask_d;
    logic [DATA_W-1:0] wdata_d;
    logic [CNT_W-1:0]  cnt_d;

    logic              valid_q;
    logic              misalign_q;
    logic [NB-1:0]     bmask_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept;
    logic              xfer;

    // The offset mask holds the address bits that must be zero for a naturally aligned access.
    always_comb begin
        sizeMask = '0;
        ofsMask  = '0;
        case (i_size)
            2'b00: begin
                sizeMask = NB'(8'h01);
                ofsMask  = '0;
            end
            2'b01: begin
                sizeMask = NB'(8'h03);
                ofsMask  = OFS_W'(1);
            end
            2'b10: begin
                sizeMask = NB'(8'h0F);
                ofsMask  = OFS_W'(3);
            end
            default: begin
                sizeMask = '1;
                ofsMask  = OFS_W'(7);
            end
        endcase
        illegal    = (DATA_W == 32) && (i_size == 2'b11);
        misalign_d = illegal || ((i_addr & ofsMask) != '0);
    end

    // Bytes beyond the access size are cleared before the shift so unused lanes read zero.
    always_comb begin
        laneMask = '0;
        for (int k = 0; k < NB; k++) begin
            laneMask[8*k +: 8] = {8{sizeMask[k]}};
        end
        shiftAmt = {i_addr, 3'b000};
        bmask_d  = '0;
        wdata_d  = '0;
        if (!misalign_d) begin
            bmask_d = sizeMask << i_addr;
            wdata_d = (i_wdata & laneMask) << shiftAmt;
        end
    end

    assign o_ready = !valid_q | i_ready;
    assign accept  = i_valid & o_ready;
    assign xfer    = valid_q & i_ready;

    // The counter tracks the result leaving the stage, even when a new one arrives the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (xfer && misalign_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            bmask_q    <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
        end else begin
            if (accept) begin
                valid_q    <= 1'b1;
                misalign_q <= misalign_d;
                bmask_q    <= bmask_d;
                wdata_q    <= wdata_d;
            end else if (xfer) begin
                valid_q <= 1'b0;
            end
            cnt_q <= cnt_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_bmask    = bmask_q;
    assign o_wdata    = wdata_q;
    assign o_misalign = misalign_q;
    assign o_mis_cnt  = cnt_q;

endmodule

// File: tb/tb_lsu_store_align.sv
// Directed bench for lsu_store_align: a 32-bit instance, a 32-bit instance with a
// 2-bit counter sharing the same stimulus, and a 64-bit instance.
module tb_lsu_store_align;

    logic        clk;
    logic        rst;

    logic        vA;
    logic [1:0]  addrA;
    logic [1:0]  sizeA;
    logic [31:0] wdataA;
    logic        readyA;

    logic        oReadyA, oValidA, misA;
    logic [3:0]  bmaskA;
    logic [31:0] wdA;
    logic [7:0]  cntA;

    logic        oReadyC, oValidC, misC;
    logic [3:0]  bmaskC;
    logic [31:0] wdC;
    logic [1:0]  cntC;

    logic        vB;
    logic [2:0]  addrB;
    logic [1:0]  sizeB;
    logic [63:0] wdataB;
    logic        readyB;

    logic        oReadyB, oValidB, misB;
    logic [7:0]  bmaskB;
    logic [63:0] wdB;
    logic [7:0]  cntB;

    int errors = 0;
    int checks = 0;

    lsu_store_align #(.DATA_W(32), .CNT_W(8)) dutA (
        .i_clk(clk), .i_rst(rst), .i_valid(vA), .o_ready(oReadyA),
        .i_addr(addrA), .i_size(sizeA), .i_wdata(wdataA), .o_valid(oValidA),
        .i_ready(readyA), .o_bmask(bmaskA), .o_wdata(wdA), .o_misalign(misA),
        .o_mis_cnt(cntA)
    );

    lsu_store_align #(.DATA_W(32), .CNT_W(2)) dutC (
        .i_clk(clk), .i_rst(rst), .i_valid(vA), .o_ready(oReadyC),
        .i_addr(addrA), .i_size(sizeA), .i_wdata(wdataA), .o_valid(oValidC),
        .i_ready(readyA), .o_bmask(bmaskC), .o_wdata(wdC), .o_misalign(misC),
        .o_mis_cnt(cntC)
    );

    lsu_store_align #(.DATA_W(64), .CNT_W(8)) dutB (
        .i_clk(clk), .i_rst(rst), .i_valid(vB), .o_ready(oReadyB),
        .i_addr(addrB), .i_size(sizeB), .i_wdata(wdataB), .o_valid(oValidB),
        .i_ready(readyB), .o_bmask(bmaskB), .o_wdata(wdB), .o_misalign(misB),
        .o_mis_cnt(cntB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] a, input logic [1:0] s,
                                 input logic [31:0] d);
        vA     = v;
        addrA  = a;
        sizeA  = s;
        wdataA = d;
    endtask

    task automatic applyStimulusB(input logic v, input logic [2:0] a, input logic [1:0] s,
                                  input logic [63:0] d);
        vB     = v;
        addrB  = a;
        sizeB  = s;
        wdataB = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  byteMaskExp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [31:0] byteDataExp [4] = '{32'h000000A5, 32'h0000A500, 32'h00A50000, 32'hA5000000};
    logic [1:0]  satExp      [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        rst    = 1'b1;
        readyA = 1'b1;
        readyB = 1'b1;
        applyStimulus(1'b0, 2'd0, 2'd0, 32'h0);
        applyStimulusB(1'b0, 3'd0, 2'd0, 64'h0);
        #2;
        $display("[TB] reset values");
        checkOutput("rst_valid", oValidA, 0);
        checkOutput("rst_bmask", bmaskA, 0);
        checkOutput("rst_wdata", wdA, 0);
        checkOutput("rst_mis", misA, 0);
        checkOutput("rst_cnt", cntA, 0);
        checkOutput("rst_ready", oReadyA, 1);
        checkOutput("rst_validB", oValidB, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] byte stores, one per cycle");
        for (int a = 0; a < 4; a++) begin
            applyStimulus(1'b1, 2'(a), 2'b00, 32'h000000A5);
            step();
            checkOutput($sformatf("byte%0d_valid", a), oValidA, 1);
            checkOutput($sformatf("byte%0d_bmask", a), bmaskA, byteMaskExp[a]);
            checkOutput($sformatf("byte%0d_wdata", a), wdA, byteDataExp[a]);
            checkOutput($sformatf("byte%0d_mis", a), misA, 0);
        end
        applyStimulus(1'b0, 2'd0, 2'd0, 32'h0);
        step();
        checkOutput("drain_valid", oValidA, 0);
        checkOutput("drain_wdata_hold", wdA, 32'hA5000000);

        $display("[TB] half stores");
        applyStimulus(1'b1, 2'd2, 2'b01, 32'h00001234);
        step();
        checkOutput("half2_bmask", bmaskA, 4'b1100);
        checkOutput("half2_wdata", wdA, 32'h12340000);
        checkOutput("half2_mis", misA, 0);
        applyStimulus(1'b1, 2'd1, 2'b01, 32'h00001234);
        step();
        checkOutput("half1_bmask", bmaskA, 0);
        checkOutput("half1_wdata", wdA, 0);
        checkOutput("half1_mis", misA, 1);
        checkOutput("half1_cnt_before", cntA, 0);
        applyStimulus(1'b0, 2'd0, 2'd0, 32'h0);
        step();
        checkOutput("half1_cnt_after", cntA, 1);
        checkOutput("half1_valid_after", oValidA, 0);

        $display("[TB] illegal double on 32-bit bus");
        applyStimulus(1'b1, 2'd0, 2'b11, 32'hFFFFFFFF);
        step();
        checkOutput("dbl32_mis", misA, 1);
        checkOutput("dbl32_bmask", bmaskA, 0);
        checkOutput("dbl32_wdata", wdA, 0);
        applyStimulus(1'b0, 2'd0, 2'd0, 32'h0);
        step();
        checkOutput("dbl32_cnt", cntA, 2);
        checkOutput("dbl32_cntC", cntC, 2);

        $display("[TB] asynchronous reset mid-cycle");
        applyStimulus(1'b1, 2'd0, 2'b10, 32'hCAFEF00D);
        step();
        applyStimulus(1'b0, 2'd0, 2'd0, 32'h0);
        checkOutput("prerst_valid", oValidA, 1);
        checkOutput("prerst_bmask", bmaskA, 4'b1111);
        checkOutput("prerst_wdata", wdA, 32'hCAFEF00D);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_valid", oValidA, 0);
        checkOutput("async_bmask", bmaskA, 0);
        checkOutput("async_cnt", cntA, 0);
        checkOutput("async_cntC", cntC, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 2'd0, 2'b10, 32'h11223344);
        step();
        checkOutput("postrst_valid", oValidA, 1);
        checkOutput("postrst_bmask", bmaskA, 4'b1111);
        checkOutput("postrst_wdata", wdA, 32'h11223344);
        checkOutput("postrst_mis", misA, 0);

        $display("[TB] counter saturation with 2-bit counter");
        applyStimulus(1'b1, 2'd1, 2'b10, 32'h0);
        step();
        checkOutput("sat_load_cntC", cntC, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) applyStimulus(1'b0, 2'd0, 2'd0, 32'h0);
            step();
            checkOutput($sformatf("sat%0d_cntC", i), cntC, satExp[i]);
            checkOutput($sformatf("sat%0d_cntA", i), cntA, 64'(i + 1));
        end
        checkOutput("sat_valid_end", oValidA, 0);

        $display("[TB] stall with misaligned result");
        readyA = 1'b0;
        applyStimulus(1'b1, 2'd3, 2'b01, 32'h0000BEEF);
        step();
        applyStimulus(1'b0, 2'd0, 2'd0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            checkOutput($sformatf("mstall%0d_ready", i), oReadyA, 0);
            checkOutput($sformatf("mstall%0d_mis", i), misA, 1);
            checkOutput($sformatf("mstall%0d_cnt", i), cntA, 5);
        end
        readyA = 1'b1;
        step();
        checkOutput("mstall_cnt_xfer", cntA, 6);
        checkOutput("mstall_valid_xfer", oValidA, 0);

        $display("[TB] stall holds outputs and blocks upstream");
        readyA = 1'b0;
        applyStimulus(1'b1, 2'd1, 2'b00, 32'h0000005A);
        step();
        applyStimulus(1'b1, 2'd3, 2'b00, 32'h00000077);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("stall%0d_ready", i), oReadyA, 0);
            checkOutput($sformatf("stall%0d_valid", i), oValidA, 1);
            checkOutput($sformatf("stall%0d_bmask", i), bmaskA, 4'b0010);
            checkOutput($sformatf("stall%0d_wdata", i), wdA, 32'h00005A00);
            checkOutput($sformatf("stall%0d_cnt", i), cntA, 6);
        end
        readyA = 1'b1;
        step();
        checkOutput("unstall_valid", oValidA, 1);
        checkOutput("unstall_bmask", bmaskA, 4'b1000);
        checkOutput("unstall_wdata", wdA, 32'h77000000);
        applyStimulus(1'b0, 2'd0, 2'd0, 32'h0);
        step();
        checkOutput("unstall_drain", oValidA, 0);
        checkOutput("unstall_cnt", cntA, 6);

        $display("[TB] 64-bit bus");
        applyStimulusB(1'b1, 3'd0, 2'b11, 64'h0123456789ABCDEF);
        step();
        checkOutput("dbl64_valid", oValidB, 1);
        checkOutput("dbl64_bmask", bmaskB, 8'hFF);
        checkOutput("dbl64_wdata", wdB, 64'h0123456789ABCDEF);
        checkOutput("dbl64_mis", misB, 0);
        applyStimulusB(1'b1, 3'd4, 2'b10, 64'hFFFFFFFFDEADBEEF);
        step();
        checkOutput("word64_bmask", bmaskB, 8'hF0);
        checkOutput("word64_wdata", wdB, 64'hDEADBEEF00000000);
        applyStimulusB(1'b1, 3'd6, 2'b01, 64'h000000000000ABCD);
        step();
        checkOutput("half64_bmask", bmaskB, 8'hC0);
        checkOutput("half64_wdata", wdB, 64'hABCD000000000000);
        applyStimulusB(1'b1, 3'd4, 2'b11, 64'h0123456789ABCDEF);
        step();
        checkOutput("dbl64mis_mis", misB, 1);
        checkOutput("dbl64mis_bmask", bmaskB, 0);
        checkOutput("dbl64mis_wdata", wdB, 0);
        applyStimulusB(1'b0, 3'd0, 2'd0, 64'h0);
        step();
        checkOutput("dbl64mis_cnt", cntB, 1);
        checkOutput("dbl64mis_valid", oValidB, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
